rob_commit_queue: RTL and testbench
===================================

Name: rob_commit_queue

Overview:
- Reorder buffer between the issue queue and the architectural register file.
- Allocates one entry per issued instruction and returns the ROB index that the issue queue writes into the regfile tag.
- Captures results from the CDB and exposes entry values to operand lookups.
- Retires one instruction per cycle in program order, driving the commit bus the regfile consumes (valid, regfile_idx, rob_idx, value). Raises a flush on a mispredicted branch at commit.

Parameters:
- DEPTH, 32, number of entries; must be a power of two.
- IDX_W, 5, ROB index width; equals log2(DEPTH).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- alloc_req  in  1  issue queue requests an entry
- alloc_has_rd  in  1  instruction writes a destination register
- alloc_rd  in  5  destination architectural register
- alloc_is_br  in  1  instruction is a branch or jump
- alloc_ack  out  1  allocation accepted this cycle
- alloc_idx  out  IDX_W  index of the accepted entry (tail)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- cdb_valid  in  1  result broadcast
- cdb_rob_idx  in  IDX_W  producing entry
- cdb_value  in  XLEN  result
- cdb_mispredict  in  1  branch resolved mispredicted (valid with cdb_valid)
- lk_idx_1, lk_idx_2  in  IDX_W  operand lookup indices
- lk_ready_1, lk_ready_2  out  1  value available
- lk_value_1, lk_value_2  out  XLEN  value
- commit_valid  out  1  regfile write this cycle
- commit_regfile_idx  out  5  destination register
- commit_rob_idx  out  IDX_W  retiring entry
- commit_value  out  XLEN  retiring value
- flush  out  1  pipeline flush (one cycle)

Behaviour:
- State:
  - head and tail pointers, IDX_W+1 bits each; the MSB is the wrap bit.
  - Per entry: busy, done, has_rd, rd, is_br, mispred, value.
  - full = (head[IDX_W-1:0]==tail[IDX_W-1:0]) and wrap bits differ. empty = head==tail.
- Reset (rst low, asynchronous):
  - head = tail = 0; all busy/done/mispred cleared.
  - Outputs: empty=1, full=0, alloc_ack=0, commit_valid=0, flush=0, lk_ready_x=0.
- Allocation:
  - alloc_ack = alloc_req & ~full & ~flush.
  - alloc_idx = tail[IDX_W-1:0] (combinational).
  - On an acked edge: entry written with busy=1, done=0, mispred=0; tail increments and wraps naturally.
  - full blocks allocation even when a commit occurs in the same cycle; there is no same-cycle slot reuse.
- Writeback:
  - On cdb_valid to a busy entry: latch value, set done=1, and set mispred=cdb_mispredict.
  - CDB to a non-busy entry is ignored.
  - A CDB write to the head entry is retired no earlier than the next cycle (done is registered).
- Retire (combinational from the head entry):
  - retire = ~empty & busy[head] & done[head].
  - commit_valid = retire & has_rd & (rd != 0). Entries with no destination, or rd=0, retire silently.
  - commit_rob_idx = head index; commit_value = entry value.
  - On a retire edge: clear busy and increment head.
- Flush:
  - flush = retire & is_br[head] & mispred[head]. The branch itself retires; commit_valid follows the normal rule (JAL/JALR link write still commits).
  - On the flush edge: all entries cleared, head = tail = 0, and allocation is refused that cycle.
- Lookup (combinational, both ports independent):
  - If done[idx]: ready=1, value=entry value.
  - Else if cdb_valid & cdb_rob_idx==idx & busy[idx]: ready=1, value=cdb_value (CDB bypass).
  - Otherwise ready=0, value=0.
- Simultaneous events:
  - alloc, CDB, and retire in one cycle are all legal and update independent fields or pointers.
  - Count is derived from the pointers only.
- Reset mid-operation discards all entries; no commit is emitted.

Decomposition:
- Shared package (extends rob_entry_structs):
  - rob_entry_t (busy, done, has_rd, rd, is_br, mispred, value).
  - The commit bus struct matching rob_to_regfile field names.
  - ROB_DEPTH and ROB_IDX_W constants, shared with the issue queue and regfile tag width.
- Optional sub-module rob_lookup_port: one lookup-with-CDB-bypass path, instantiated twice.

Test Plan:
- Reset asserted mid-run with 5 busy entries -> empty=1, commit_valid=0, and the next alloc returns alloc_idx=0.
- Alloc A(rd=3), B(rd=4), C(rd=5) at idx 0,1,2. CDB order C=0x33, A=0x11, B=0x22 -> commits idx0/r3/0x11, idx1/r4/0x22, idx2/r5/0x33 in consecutive cycles, with none before A completes.
- Alloc 32 entries with no CDB -> full=1, and the 33rd alloc_req gives alloc_ack=0. Then complete idx0 and retire -> full=0, and the next alloc returns idx0 with the wrap bit toggled.
- Lookup lk_idx_1=7 while cdb_valid with cdb_rob_idx=7, value=0xDEAD -> lk_ready_1=1, lk_value_1=0xDEAD in the same cycle. The following cycle it returns the same value from storage.
- Branch at idx 2 with younger entries 3–6; CDB mispredict for idx 2 -> flush=1 for one cycle on its retire; next cycle empty=1 and the next alloc returns idx0.
- Entry with rd=0 completes with 0x55 -> retires with commit_valid=0, head advances, and the following entry commits next cycle.

Source files
------------

// File: rtl/rob_commit_queue_pkg.sv
// Shared reorder-buffer types and sizing, also used by the issue queue
// (ROB tag width) and the register file (commit bus).
package rob_commit_queue_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = 5;
  localparam int ROB_XLEN  = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 has_rd;
    logic [REG_IDX_W-1:0] rd;
    logic                 is_br;
    logic                 mispred;
    logic [ROB_XLEN-1:0]  value;
  } rob_entry_t;

  // Field names match the regfile-side rob_to_regfile bundle.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] regfile_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [ROB_XLEN-1:0]  value;
  } rob_commit_t;

endpackage

// File: rtl/rob_lookup_port.sv
// One operand-lookup path: stored result if complete, else a same-cycle
// bypass from the CDB when it is writing this (busy) entry.
module rob_lookup_port #(
  parameter int IDX_W = 5,
  parameter int XLEN  = 32
) (
  input  logic [IDX_W-1:0] lk_idx,
  input  logic             entry_done,
  input  logic             entry_busy,
  input  logic [XLEN-1:0]  entry_value,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_rob_idx,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             lk_ready,
  output logic [XLEN-1:0]  lk_value
);

  always_comb begin
    lk_ready = 1'b0;
    lk_value = '0;
    if (entry_done) begin
      lk_ready = 1'b1;
      lk_value = entry_value;
    end else if (cdb_valid && (cdb_rob_idx == lk_idx) && entry_busy) begin
      lk_ready = 1'b1;
      lk_value = cdb_value;
    end
  end

endmodule

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocate, out-of-order CDB writeback, in-order
// single-wide retire onto the regfile commit bus, flush on mispredicted branch.
module rob_commit_queue
  import rob_commit_queue_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int XLEN  = ROB_XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic                 alloc_has_rd,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  input  logic                 alloc_is_br,
  output logic                 alloc_ack,
  output logic [IDX_W-1:0]     alloc_idx,
  output logic                 full,
  output logic                 empty,
  input  logic                 cdb_valid,
  input  logic [IDX_W-1:0]     cdb_rob_idx,
  input  logic [XLEN-1:0]      cdb_value,
  input  logic                 cdb_mispredict,
  input  logic [IDX_W-1:0]     lk_idx_1,
  input  logic [IDX_W-1:0]     lk_idx_2,
  output logic                 lk_ready_1,
  output logic                 lk_ready_2,
  output logic [XLEN-1:0]      lk_value_1,
  output logic [XLEN-1:0]      lk_value_2,
  output logic                 commit_valid,
  output logic [REG_IDX_W-1:0] commit_regfile_idx,
  output logic [IDX_W-1:0]     commit_rob_idx,
  output logic [XLEN-1:0]      commit_value,
  output logic                 flush
);

  logic [IDX_W:0]         head, tail;
  logic [IDX_W-1:0]       head_i, tail_i;
  logic [DEPTH-1:0]       busy, done, mispred;
  logic [DEPTH-1:0]       has_rd, is_br;
  logic [REG_IDX_W-1:0]   rd    [DEPTH];
  logic [XLEN-1:0]        value [DEPTH];
  logic                   retire, cdb_hit;

  assign head_i = head[IDX_W-1:0];
  assign tail_i = tail[IDX_W-1:0];

  assign empty = (head == tail);
  assign full  = (head_i == tail_i) && (head[IDX_W] != tail[IDX_W]);

  assign retire  = !empty && busy[head_i] && done[head_i];
  assign flush   = retire && is_br[head_i] && mispred[head_i];
  assign cdb_hit = cdb_valid && busy[cdb_rob_idx];

  // rst gates the ack so nothing is granted while reset is held.
  assign alloc_ack = rst && alloc_req && !full && !flush;
  assign alloc_idx = tail_i;

  assign commit_valid       = retire && has_rd[head_i] && (rd[head_i] != '0);
  assign commit_regfile_idx = rd[head_i];
  assign commit_rob_idx     = head_i;
  assign commit_value       = value[head_i];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      busy    <= '0;
      done    <= '0;
      mispred <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      busy    <= '0;
      done    <= '0;
      mispred <= '0;
    end else begin
      if (alloc_ack) begin
        busy[tail_i]    <= 1'b1;
        done[tail_i]    <= 1'b0;
        mispred[tail_i] <= 1'b0;
        tail            <= tail + 1'b1;
      end
      // Tail entry is never busy unless full, so alloc and CDB never collide.
      if (cdb_hit) begin
        done[cdb_rob_idx]    <= 1'b1;
        mispred[cdb_rob_idx] <= cdb_mispredict;
      end
      if (retire) begin
        busy[head_i] <= 1'b0;
        head         <= head + 1'b1;
      end
    end
  end

  // Payload fields are only meaningful under busy/done, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc_ack) begin
      has_rd[tail_i] <= alloc_has_rd;
      rd[tail_i]     <= alloc_rd;
      is_br[tail_i]  <= alloc_is_br;
    end
    if (cdb_hit) begin
      value[cdb_rob_idx] <= cdb_value;
    end
  end

  rob_lookup_port #(.IDX_W(IDX_W), .XLEN(XLEN)) u_lookup_1 (
    .lk_idx      (lk_idx_1),
    .entry_done  (done[lk_idx_1]),
    .entry_busy  (busy[lk_idx_1]),
    .entry_value (value[lk_idx_1]),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_value   (cdb_value),
    .lk_ready    (lk_ready_1),
    .lk_value    (lk_value_1)
  );

  rob_lookup_port #(.IDX_W(IDX_W), .XLEN(XLEN)) u_lookup_2 (
    .lk_idx      (lk_idx_2),
    .entry_done  (done[lk_idx_2]),
    .entry_busy  (busy[lk_idx_2]),
    .entry_value (value[lk_idx_2]),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_value   (cdb_value),
    .lk_ready    (lk_ready_2),
    .lk_value    (lk_value_2)
  );

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue: vector table plus hand sequences for
// full/wrap, mispredict flush and mid-run reset.
module tb_rob_commit_queue;

  localparam int IDX_W = 5;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_req, alloc_has_rd, alloc_is_br;
  logic [4:0]       alloc_rd;
  logic             alloc_ack, full, empty;
  logic [IDX_W-1:0] alloc_idx;
  logic             cdb_valid, cdb_mispredict;
  logic [IDX_W-1:0] cdb_rob_idx;
  logic [XLEN-1:0]  cdb_value;
  logic [IDX_W-1:0] lk_idx_1, lk_idx_2;
  logic             lk_ready_1, lk_ready_2;
  logic [XLEN-1:0]  lk_value_1, lk_value_2;
  logic             commit_valid, flush;
  logic [4:0]       commit_regfile_idx;
  logic [IDX_W-1:0] commit_rob_idx;
  logic [XLEN-1:0]  commit_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_commit_queue #(.DEPTH(32), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
    .alloc_is_br(alloc_is_br), .alloc_ack(alloc_ack), .alloc_idx(alloc_idx),
    .full(full), .empty(empty),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict),
    .lk_idx_1(lk_idx_1), .lk_idx_2(lk_idx_2),
    .lk_ready_1(lk_ready_1), .lk_ready_2(lk_ready_2),
    .lk_value_1(lk_value_1), .lk_value_2(lk_value_2),
    .commit_valid(commit_valid), .commit_regfile_idx(commit_regfile_idx),
    .commit_rob_idx(commit_rob_idx), .commit_value(commit_value),
    .flush(flush)
  );

  typedef struct {
    int          req, hrd, rd, br;
    int          cv, cidx;
    int unsigned cval;
    int          cmis, lk1, lk2;
    int          ack, aidx, emp, ful, fl;
    int          ccv, crd, cri;
    int unsigned cvo;
    int          lr1;
    int unsigned lv1;
    int          lr2;
    int unsigned lv2;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_ctl(input string n, input int ack, input int aidx, input int emp,
                         input int ful, input int fl);
    chk(n, 64'({alloc_ack, alloc_idx, empty, full, flush}),
        64'({1'(ack), 5'(aidx), 1'(emp), 1'(ful), 1'(fl)}));
  endtask

  task automatic chk_commit(input string n, input int v, input int rd, input int ri,
                            input int unsigned val);
    logic [63:0] got;
    got = commit_valid ? 64'({1'b1, commit_regfile_idx, commit_rob_idx, commit_value}) : 64'd0;
    chk(n, got, 64'({1'(v), 5'(rd), 5'(ri), 32'(val)}));
  endtask

  task automatic chk_lk1(input string n, input int r, input int unsigned val);
    chk(n, 64'({lk_ready_1, lk_value_1}), 64'({1'(r), 32'(val)}));
  endtask

  task automatic chk_lk2(input string n, input int r, input int unsigned val);
    chk(n, 64'({lk_ready_2, lk_value_2}), 64'({1'(r), 32'(val)}));
  endtask

  task automatic idle();
    alloc_req = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0; alloc_is_br = 1'b0;
    cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_value = '0; cdb_mispredict = 1'b0;
    lk_idx_1 = '0; lk_idx_2 = '0;
  endtask

  task automatic drive(input int req, input int hrd, input int rd, input int br,
                       input int cv, input int cidx, input int unsigned cval, input int cmis);
    alloc_req = 1'(req); alloc_has_rd = 1'(hrd); alloc_rd = 5'(rd); alloc_is_br = 1'(br);
    cdb_valid = 1'(cv); cdb_rob_idx = 5'(cidx); cdb_value = 32'(cval);
    cdb_mispredict = 1'(cmis);
  endtask

  task automatic pulse_reset(input string n);
    @(negedge clk);
    idle();
    #1 rst = 1'b0;
    #1;
    chk_ctl({n, "_ctl"}, 0, 0, 1, 0, 0);
    chk_commit({n, "_commit"}, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl [23];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    //         req hrd rd br  cv cidx cval     mis lk1 lk2  ack aidx emp ful fl  ccv crd cri cvo      lr1 lv1      lr2 lv2
    tbl[0]  = '{0, 0, 0, 0,  0, 0, 'h0,    0, 0, 0,   0, 0, 1, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    0, 'h0};
    tbl[1]  = '{1, 1, 3, 0,  0, 0, 'h0,    0, 0, 0,   1, 0, 1, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    0, 'h0};
    tbl[2]  = '{1, 1, 4, 0,  0, 0, 'h0,    0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    0, 'h0};
    tbl[3]  = '{1, 1, 5, 0,  0, 0, 'h0,    0, 0, 0,   1, 2, 0, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    0, 'h0};
    tbl[4]  = '{0, 0, 0, 0,  1, 2, 'h33,   0, 2, 0,   0, 3, 0, 0, 0,  0, 0, 0, 'h0,    1, 'h33,   0, 'h0};
    tbl[5]  = '{0, 0, 0, 0,  1, 0, 'h11,   0, 2, 0,   0, 3, 0, 0, 0,  0, 0, 0, 'h0,    1, 'h33,   1, 'h11};
    tbl[6]  = '{0, 0, 0, 0,  1, 1, 'h22,   0, 0, 2,   0, 3, 0, 0, 0,  1, 3, 0, 'h11,   1, 'h11,   1, 'h33};
    tbl[7]  = '{0, 0, 0, 0,  0, 0, 'h0,    0, 1, 0,   0, 3, 0, 0, 0,  1, 4, 1, 'h22,   1, 'h22,   1, 'h11};
    tbl[8]  = '{0, 0, 0, 0,  0, 0, 'h0,    0, 7, 0,   0, 3, 0, 0, 0,  1, 5, 2, 'h33,   0, 'h0,    1, 'h11};
    tbl[9]  = '{0, 0, 0, 0,  0, 0, 'h0,    0, 7, 0,   0, 3, 1, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    1, 'h11};
    tbl[10] = '{1, 1, 0, 0,  0, 0, 'h0,    0, 7, 0,   1, 3, 1, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    1, 'h11};
    tbl[11] = '{1, 1, 6, 0,  0, 0, 'h0,    0, 7, 0,   1, 4, 0, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    1, 'h11};
    tbl[12] = '{1, 0, 9, 0,  0, 0, 'h0,    0, 7, 0,   1, 5, 0, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    1, 'h11};
    tbl[13] = '{1, 1, 8, 0,  0, 0, 'h0,    0, 7, 0,   1, 6, 0, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    1, 'h11};
    tbl[14] = '{1, 1, 10, 0, 0, 0, 'h0,    0, 7, 0,   1, 7, 0, 0, 0,  0, 0, 0, 'h0,    0, 'h0,    1, 'h11};
    tbl[15] = '{0, 0, 0, 0,  1, 7, 'hDEAD, 0, 7, 0,   0, 8, 0, 0, 0,  0, 0, 0, 'h0,    1, 'hDEAD, 1, 'h11};
    tbl[16] = '{0, 0, 0, 0,  1, 3, 'h55,   0, 7, 0,   0, 8, 0, 0, 0,  0, 0, 0, 'h0,    1, 'hDEAD, 1, 'h11};
    tbl[17] = '{0, 0, 0, 0,  1, 4, 'h66,   0, 3, 0,   0, 8, 0, 0, 0,  0, 0, 0, 'h0,    1, 'h55,   1, 'h11};
    tbl[18] = '{0, 0, 0, 0,  1, 5, 'h77,   0, 5, 0,   0, 8, 0, 0, 0,  1, 6, 4, 'h66,   1, 'h77,   1, 'h11};
    tbl[19] = '{1, 1, 11, 0, 1, 6, 'h88,   0, 0, 0,   1, 8, 0, 0, 0,  0, 0, 0, 'h0,    1, 'h11,   1, 'h11};
    tbl[20] = '{0, 0, 0, 0,  0, 0, 'h0,    0, 6, 0,   0, 9, 0, 0, 0,  1, 8, 6, 'h88,   1, 'h88,   1, 'h11};
    tbl[21] = '{0, 0, 0, 0,  0, 0, 'h0,    0, 8, 0,   0, 9, 0, 0, 0,  1, 10, 7, 'hDEAD, 0, 'h0,    1, 'h11};
    tbl[22] = '{0, 0, 0, 0,  0, 0, 'h0,    0, 0, 0,   0, 9, 0, 0, 0,  0, 0, 0, 'h0,    1, 'h11,   1, 'h11};

    // Reset held with a pending alloc request.
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    alloc_req = 1'b1;
    #1;
    chk_ctl("reset_ctl", 0, 0, 1, 0, 0);
    chk_commit("reset_commit", 0, 0, 0, 0);
    chk_lk1("reset_lk1", 0, 0);
    chk_lk2("reset_lk2", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].hrd, tbl[i].rd, tbl[i].br,
            tbl[i].cv, tbl[i].cidx, tbl[i].cval, tbl[i].cmis);
      lk_idx_1 = 5'(tbl[i].lk1);
      lk_idx_2 = 5'(tbl[i].lk2);
      #1;
      chk_ctl($sformatf("vec%0d_ctl", i), tbl[i].ack, tbl[i].aidx, tbl[i].emp, tbl[i].ful, tbl[i].fl);
      chk_commit($sformatf("vec%0d_commit", i), tbl[i].ccv, tbl[i].crd, tbl[i].cri, tbl[i].cvo);
      chk_lk1($sformatf("vec%0d_lk1", i), tbl[i].lr1, tbl[i].lv1);
      chk_lk2($sformatf("vec%0d_lk2", i), tbl[i].lr2, tbl[i].lv2);
    end

    // Fill to full, block the 33rd, retire idx0, then wrap-allocate idx0.
    pulse_reset("rst_a");
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      drive(1, 1, (k % 31) + 1, 0, 0, 0, 0, 0);
      #1 chk_ctl($sformatf("fill%0d", k), 1, k, (k == 0) ? 1 : 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 'h99, 0);
    #1 chk_ctl("full_block", 0, 0, 0, 1, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_ctl("full_with_commit", 0, 0, 0, 1, 0);
    chk_commit("wrap_commit0", 1, 1, 0, 'h99);
    @(negedge clk);
    drive(1, 1, 20, 0, 0, 0, 0, 0);
    #1;
    chk_ctl("wrap_alloc", 1, 0, 0, 0, 0);
    chk_commit("wrap_no_commit", 0, 0, 0, 0);
    @(negedge clk);
    idle();
    #1;
    chk_ctl("wrap_full_again", 0, 1, 0, 1, 0);
    chk_lk1("realloc_done_clr", 0, 0);

    // Mispredicted branch at idx2 with younger entries 3..6.
    pulse_reset("rst_b");
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive(1, 1, k + 1, (k == 2) ? 1 : 0, 0, 0, 0, 0);
      #1 chk_ctl($sformatf("br_alloc%0d", k), 1, k, (k == 0) ? 1 : 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 'h10, 0);
    #1 chk_commit("br_c0_pending", 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 'h20, 0);
    #1;
    chk_commit("br_c0", 1, 1, 0, 'h10);
    chk_ctl("br_noflush0", 0, 7, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 2, 'h30, 1);
    #1 chk_commit("br_c1", 1, 2, 1, 'h20);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_ctl("br_flush", 0, 7, 0, 0, 1);
    chk_commit("br_link_commit", 1, 3, 2, 'h30);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 4, 'hBB, 0);
    lk_idx_1 = 5'd4;
    #1;
    chk_ctl("post_flush", 0, 0, 1, 0, 0);
    chk_lk1("cdb_nonbusy_bypass", 0, 0);
    @(negedge clk);
    idle();
    lk_idx_1 = 5'd4;
    #1 chk_lk1("cdb_nonbusy_store", 0, 0);

    // Five busy entries, head complete, then asynchronous reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, 1, 7 + k, 0, 0, 0, 0, 0);
      #1 chk_ctl($sformatf("pre_rst_alloc%0d", k), 1, k, (k == 0) ? 1 : 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 'h5A, 0);
    @(negedge clk);
    idle();
    #1 chk_commit("pre_reset_commit", 1, 7, 0, 'h5A);
    #1 rst = 1'b0;
    #1;
    chk_ctl("midrun_reset", 0, 0, 1, 0, 0);
    chk_commit("midrun_reset_commit", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 9, 0, 0, 0, 0, 0);
    #1 chk_ctl("alloc_after_reset", 1, 0, 1, 0, 0);
    @(negedge clk);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
